// File: rtl/sha2_pkg.sv
// Shared SHA-2 message-schedule definitions: FSM states, sigma rotate/shift
// amounts for both word widths, and the round-count derivation.
package sha2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } sched_state_e;

    localparam int SHA256_S0_ROT1 = 7;
    localparam int SHA256_S0_ROT2 = 18;
    localparam int SHA256_S0_SHR  = 3;
    localparam int SHA256_S1_ROT1 = 17;
    localparam int SHA256_S1_ROT2 = 19;
    localparam int SHA256_S1_SHR  = 10;

    localparam int SHA512_S0_ROT1 = 1;
    localparam int SHA512_S0_ROT2 = 8;
    localparam int SHA512_S0_SHR  = 7;
    localparam int SHA512_S1_ROT1 = 19;
    localparam int SHA512_S1_ROT2 = 61;
    localparam int SHA512_S1_SHR  = 6;

    function automatic int sha2_rounds(input int word_w);
        return (word_w == 64) ? 80 : 64;
    endfunction

endpackage

// File: rtl/sha2_sched_sigma.sv
// Small-sigma functions s0/s1 of the SHA-2 message schedule; purely combinational.
module sha2_sched_sigma
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] s0,
    output logic [WORD_W-1:0] s1
);

    localparam bit WIDE  = (WORD_W == 64);
    localparam int S0_R1 = WIDE ? SHA512_S0_ROT1 : SHA256_S0_ROT1;
    localparam int S0_R2 = WIDE ? SHA512_S0_ROT2 : SHA256_S0_ROT2;
    localparam int S0_SH = WIDE ? SHA512_S0_SHR  : SHA256_S0_SHR;
    localparam int S1_R1 = WIDE ? SHA512_S1_ROT1 : SHA256_S1_ROT1;
    localparam int S1_R2 = WIDE ? SHA512_S1_ROT2 : SHA256_S1_ROT2;
    localparam int S1_SH = WIDE ? SHA512_S1_SHR  : SHA256_S1_SHR;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] v, input int n);
        return (v >> n) | (v << (WORD_W - n));
    endfunction

    assign s0 = rotr(x, S0_R1) ^ rotr(x, S0_R2) ^ (x >> S0_SH);
    assign s1 = rotr(x, S1_R1) ^ rotr(x, S1_R2) ^ (x >> S1_SH);

endmodule

// File: rtl/sha2_msg_sched.sv
// SHA-256/512 message scheduler: loads M0..M15 into a 16-entry ring buffer and
// streams W[0..ROUNDS-1] one word per handshake, expanding in place.
module sha2_msg_sched
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_new_block,
    input  logic              abort,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [WORD_W-1:0] m_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [WORD_W-1:0] w_data,
    output logic [6:0]        w_idx,
    output logic              w_last,
    output logic              busy
);

    localparam int         ROUNDS   = sha2_rounds(WORD_W);
    localparam logic [6:0] LAST_IDX = 7'(ROUNDS - 1);

    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
        $error("sha2_msg_sched: WORD_W must be 32 or 64");
    end

    sched_state_e      state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [6:0]        t_q, t_d;
    logic [WORD_W-1:0] wbuf_q [16];

    logic              run, m_hs, w_hs, in_sched;
    logic [3:0]        idx_cur, idx_m2, idx_m7, idx_m15;
    logic [WORD_W-1:0] s0_w, s1_w, unused_s1_w, unused_s0_w, w_next;

    assign run      = (state_q == ST_RUN);
    assign m_ready  = (state_q == ST_LOAD);
    assign m_hs     = m_valid && m_ready;
    assign w_hs     = run && w_ready;
    assign in_sched = (t_q >= 7'd16);

    // Ring-buffer taps relative to t, all mod 16.
    assign idx_cur = t_q[3:0];
    assign idx_m2  = t_q[3:0] - 4'd2;
    assign idx_m7  = t_q[3:0] + 4'd9;
    assign idx_m15 = t_q[3:0] + 4'd1;

    sha2_sched_sigma #(.WORD_W(WORD_W)) u_sigma_m15 (
        .x  (wbuf_q[idx_m15]),
        .s0 (s0_w),
        .s1 (unused_s1_w)
    );

    sha2_sched_sigma #(.WORD_W(WORD_W)) u_sigma_m2 (
        .x  (wbuf_q[idx_m2]),
        .s0 (unused_s0_w),
        .s1 (s1_w)
    );

    assign w_next = in_sched ? (s1_w + wbuf_q[idx_m7] + s0_w + wbuf_q[idx_cur])
                             : wbuf_q[idx_cur];

    assign w_valid = run;
    assign w_data  = run ? w_next : '0;
    assign w_idx   = run ? t_q : '0;
    assign w_last  = run && (t_q == LAST_IDX);
    assign busy    = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            t_d     = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_new_block) begin
                        state_d = ST_LOAD;
                        cnt_d   = '0;
                        t_d     = '0;
                    end
                end
                ST_LOAD: begin
                    if (m_hs) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd15) begin
                            state_d = ST_RUN;
                            t_d     = '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_hs) begin
                        if (t_q == LAST_IDX) begin
                            state_d = ST_IDLE;
                            t_d     = '0;
                        end else begin
                            t_d = t_q + 7'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
        end
    end

    // Buffer is data only: never reset, overwritten by the next full load.
    always_ff @(posedge clk) begin
        if (m_hs) begin
            wbuf_q[cnt_q] <= m_data;
        end else if (w_hs && in_sched) begin
            wbuf_q[idx_cur] <= w_next;
        end
    end

endmodule

// File: tb/tb_sha2_msg_sched.sv
// Bench for sha2_msg_sched: SHA-256 and SHA-512 instances checked against a
// full-array W recurrence model, with backpressure, abort, reset and back-to-back blocks.
module tb_sha2_msg_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start, abort, m_valid, w_ready;
    logic [31:0] m_data;
    logic        m_ready, w_valid, w_last, busy;
    logic [31:0] w_data;
    logic [6:0]  w_idx;

    logic        start64, abort64, m_valid64, w_ready64;
    logic [63:0] m_data64;
    logic        m_ready64, w_valid64, w_last64, busy64;
    logic [63:0] w_data64;
    logic [6:0]  w_idx64;

    sha2_msg_sched #(.WORD_W(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .start_new_block(start), .abort(abort),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .w_idx(w_idx), .w_last(w_last), .busy(busy)
    );

    sha2_msg_sched #(.WORD_W(64)) dut64 (
        .clk(clk), .reset_n(reset_n), .start_new_block(start64), .abort(abort64),
        .m_valid(m_valid64), .m_ready(m_ready64), .m_data(m_data64),
        .w_valid(w_valid64), .w_ready(w_ready64), .w_data(w_data64),
        .w_idx(w_idx64), .w_last(w_last64), .busy(busy64)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] msg   [16];
    logic [63:0] exp_w [80];
    logic [63:0] got_w [80];
    int          last_seen;

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
        logic [63:0] m;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        return ((x >> n) | (x << (w - n))) & m;
    endfunction

    function automatic void compute_exp(input int w);
        logic [63:0] m, s0, s1, x0, x1;
        int rounds;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        rounds = (w == 64) ? 80 : 64;
        for (int t = 0; t < 80; t++) exp_w[t] = '0;
        for (int t = 0; t < rounds; t++) begin
            if (t < 16) begin
                exp_w[t] = msg[t] & m;
            end else begin
                x0 = exp_w[t-15];
                x1 = exp_w[t-2];
                if (w == 64) begin
                    s0 = rotr(x0, 1, 64) ^ rotr(x0, 8, 64) ^ (x0 >> 7);
                    s1 = rotr(x1, 19, 64) ^ rotr(x1, 61, 64) ^ (x1 >> 6);
                end else begin
                    s0 = rotr(x0, 7, 32) ^ rotr(x0, 18, 32) ^ (x0 >> 3);
                    s1 = rotr(x1, 17, 32) ^ rotr(x1, 19, 32) ^ (x1 >> 10);
                end
                exp_w[t] = (s1 + exp_w[t-7] + s0 + exp_w[t-16]) & m;
            end
        end
    endfunction

    function automatic void set_abc(input int w);
        for (int k = 0; k < 16; k++) msg[k] = '0;
        msg[0]  = (w == 64) ? 64'h6162_6380_0000_0000 : 64'h0000_0000_6162_6380;
        msg[15] = 64'h18;
    endfunction

    function automatic void set_random();
        for (int k = 0; k < 16; k++) msg[k] = {$urandom, $urandom};
    endfunction

    task automatic load32(input int gaps);
        int k = 0;
        int cyc = 0;
        logic took;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (k < 16 && cyc < 500) begin
            if (gaps != 0 && $urandom_range(0, 2) == 0) begin
                m_valid = 1'b0;
            end else begin
                m_valid = 1'b1;
                m_data  = msg[k][31:0];
            end
            start = (gaps != 0) && ($urandom_range(0, 4) == 0);
            @(negedge clk);
            took = m_valid && m_ready;
            @(posedge clk); #1;
            if (took) k++;
            cyc++;
        end
        m_valid = 1'b0;
        start   = 1'b0;
        if (k < 16) begin
            n_cmp++; n_bad++;
            $display("FAIL load_timeout loaded=%0d required=16", k);
        end
        n_cmp++;
        if ({w_valid, w_idx, m_ready, busy} !== {1'b1, 7'd0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL first_w_latency got valid=%b idx=%0d m_ready=%b busy=%b required 1/0/0/1",
                     w_valid, w_idx, m_ready, busy);
        end
    endtask

    // Returns at posedge+1 after the final handshake, or at the negedge of t==stop_at.
    task automatic run32(input int mode, input int stop_at, input int poke_at);
        int t = 0;
        int cyc = 0;
        logic hs;
        last_seen = -1;
        while (t < 64 && cyc < 1000) begin
            w_ready = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            start   = (t == poke_at);
            @(negedge clk);
            n_cmp++;
            if ({w_valid, w_idx, w_data, w_last} !== {1'b1, 7'(t), exp_w[t][31:0], (t == 63)}) begin
                n_bad++;
                $display("FAIL w_stream t=%0d got valid=%b idx=%0d data=%h last=%b required data=%h",
                         t, w_valid, w_idx, w_data, w_last, exp_w[t][31:0]);
            end
            got_w[t] = 64'(w_data);
            if (w_last) last_seen = int'(w_idx);
            if (t == stop_at) begin
                start = 1'b0;
                return;
            end
            hs = w_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (hs) t++;
            cyc++;
        end
        w_ready = 1'b0;
        if (t < 64) begin
            n_cmp++; n_bad++;
            $display("FAIL run_timeout t=%0d required=64", t);
        end
        n_cmp++;
        if ({w_valid, busy, w_idx, w_data, w_last, m_ready} !== '0) begin
            n_bad++;
            $display("FAIL idle_after_run got valid=%b busy=%b idx=%0d data=%h last=%b m_ready=%b required all 0",
                     w_valid, busy, w_idx, w_data, w_last, m_ready);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({m_ready, w_valid, w_last, busy, w_idx, w_data} !== '0) begin
            n_bad++;
            $display("FAIL reset32 got m_ready=%b valid=%b last=%b busy=%b idx=%0d data=%h required all 0",
                     m_ready, w_valid, w_last, busy, w_idx, w_data);
        end
        n_cmp++;
        if ({m_ready64, w_valid64, w_last64, busy64, w_idx64, w_data64} !== '0) begin
            n_bad++;
            $display("FAIL reset64 got m_ready=%b valid=%b busy=%b data=%h required all 0",
                     m_ready64, w_valid64, busy64, w_data64);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_abc();
        set_abc(32);
        compute_exp(32);
        load32(0);
        run32(0, -1, -1);
        n_cmp++;
        if (got_w[0] !== 64'h6162_6380) begin
            n_bad++; $display("FAIL abc_w0 got=%h required=61626380", got_w[0]);
        end
        n_cmp++;
        if (got_w[16] !== 64'h6162_6380) begin
            n_bad++; $display("FAIL abc_w16 got=%h required=61626380", got_w[16]);
        end
        n_cmp++;
        if (got_w[17] !== 64'h000F_0000) begin
            n_bad++; $display("FAIL abc_w17 got=%h required=000f0000", got_w[17]);
        end
        n_cmp++;
        if (last_seen != 63) begin
            n_bad++; $display("FAIL abc_last got=%0d required=63", last_seen);
        end
    endtask

    task automatic test_backpressure();
        set_abc(32);
        compute_exp(32);
        load32(1);
        run32(1, -1, -1);
        n_cmp++;
        if (got_w[17] !== 64'h000F_0000 || last_seen != 63) begin
            n_bad++;
            $display("FAIL bp_abc got w17=%h last=%0d required 000f0000/63", got_w[17], last_seen);
        end
        set_random();
        compute_exp(32);
        load32(1);
        run32(1, -1, -1);
    endtask

    task automatic test_abort();
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        m_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            m_data = $urandom;
            @(posedge clk); #1;
        end
        m_valid = 1'b0;
        abort   = 1'b1;
        start   = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        n_cmp++;
        if ({m_ready, busy} !== 2'b00) begin
            n_bad++; $display("FAIL abort_idle got m_ready=%b busy=%b required 0/0", m_ready, busy);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL abort_start_prio got busy=%b required 0", busy);
        end
        set_abc(32);
        compute_exp(32);
        load32(0);
        run32(0, -1, -1);
        n_cmp++;
        if (got_w[16] !== 64'h6162_6380 || got_w[17] !== 64'h000F_0000) begin
            n_bad++;
            $display("FAIL abort_reload got w16=%h w17=%h required 61626380/000f0000", got_w[16], got_w[17]);
        end
    endtask

    task automatic test_reset_mid_run();
        set_random();
        compute_exp(32);
        load32(0);
        run32(0, 30, 10);
        reset_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({m_ready, w_valid, w_last, busy, w_idx, w_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_run got valid=%b busy=%b idx=%0d data=%h required all 0",
                     w_valid, busy, w_idx, w_data);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({w_valid, busy, m_ready} !== 3'b000) begin
                n_bad++;
                $display("FAIL quiet_after_reset cyc=%0d got valid=%b busy=%b m_ready=%b required 0",
                         i, w_valid, busy, m_ready);
            end
        end
        w_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] m0_b;
        set_random();
        compute_exp(32);
        load32(0);
        run32(0, -1, 63);
        set_random();
        m0_b = msg[0][31:0];
        compute_exp(32);
        load32(0);
        run32(1, -1, -1);
        n_cmp++;
        if (got_w[0][31:0] !== m0_b) begin
            n_bad++; $display("FAIL b2b_w0 got=%h required=%h", got_w[0][31:0], m0_b);
        end
    endtask

    task automatic test_sha512();
        int k = 0;
        int t = 0;
        int cyc = 0;
        int last64 = -1;
        logic took;
        set_abc(64);
        compute_exp(64);
        start64 = 1'b1;
        @(posedge clk); #1;
        start64   = 1'b0;
        m_valid64 = 1'b1;
        while (k < 16 && cyc < 100) begin
            m_data64 = msg[k];
            @(negedge clk);
            took = m_ready64;
            @(posedge clk); #1;
            if (took) k++;
            cyc++;
        end
        m_valid64 = 1'b0;
        w_ready64 = 1'b1;
        while (t < 80 && cyc < 400) begin
            @(negedge clk);
            n_cmp++;
            if ({w_valid64, w_idx64, w_data64, w_last64} !== {1'b1, 7'(t), exp_w[t], (t == 79)}) begin
                n_bad++;
                $display("FAIL w512 t=%0d got valid=%b idx=%0d data=%h last=%b required data=%h",
                         t, w_valid64, w_idx64, w_data64, w_last64, exp_w[t]);
            end
            got_w[t] = w_data64;
            if (w_last64) last64 = int'(w_idx64);
            @(posedge clk); #1;
            t++;
            cyc++;
        end
        w_ready64 = 1'b0;
        n_cmp++;
        if (got_w[16] !== 64'h6162_6380_0000_0000) begin
            n_bad++; $display("FAIL abc512_w16 got=%h required=6162638000000000", got_w[16]);
        end
        n_cmp++;
        if (last64 != 79 || busy64 !== 1'b0) begin
            n_bad++; $display("FAIL abc512_last got=%0d busy=%b required 79/0", last64, busy64);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0; abort   = 1'b0; m_valid   = 1'b0; w_ready   = 1'b0; m_data   = '0;
        start64   = 1'b0; abort64 = 1'b0; m_valid64 = 1'b0; w_ready64 = 1'b0; m_data64 = '0;
        test_reset();
        test_abc();
        test_backpressure();
        test_abort();
        test_reset_mid_run();
        test_back_to_back();
        test_sha512();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
